// File: rtl/ibox_sched.sv
// Two-port round-robin scheduler in front of a shared Ibox.
// It keeps one op in flight, holds the Ibox operands stable and returns tagged results.
module ibox_sched #(
  parameter int MUL_LATENCY = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_a,
  input  logic [63:0]      req0_b,
  input  logic [30:0]      req0_control,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_a,
  input  logic [63:0]      req1_b,
  input  logic [30:0]      req1_control,
  input  logic [TAG_W-1:0] req1_tag,

  output logic [63:0]      ibox_a,
  output logic [63:0]      ibox_b,
  output logic [30:0]      ibox_control,
  input  logic [63:0]      ibox_result,
  input  logic             ibox_flag,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_port,
  output logic [TAG_W-1:0] resp_tag,
  output logic [63:0]      resp_result,
  output logic             resp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [63:0]      a_q, a_d;
  logic [63:0]      b_q, b_d;
  logic [30:0]      ctrl_q, ctrl_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             port_q, port_d;
  logic             ovf_q, ovf_d;
  logic             last_grant_q, last_grant_d;

  logic             grant0, grant1;
  logic             can_issue;
  logic             xfer;
  logic [30:0]      sel_ctrl;

  // Multiply-class ops (7..9) occupy the Ibox for MUL_LATENCY cycles; all others, 10..15 included, take one.
  function automatic logic [3:0] exec_cycles(input logic [3:0] alu);
    if (alu == 4'd7 || alu == 4'd8 || alu == 4'd9) begin
      return 4'(MUL_LATENCY);
    end
    return 4'd1;
  endfunction

  // On a tie the port that was not granted last wins; last_grant_q resets to 1 so port 0 wins first.
  assign grant0    = req0_valid & (~req1_valid | last_grant_q);
  assign grant1    = req1_valid & (~req0_valid | ~last_grant_q);
  assign can_issue = (state_q == IDLE) & ~rst;

  assign req0_ready = can_issue & grant0;
  assign req1_ready = can_issue & grant1;
  assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel_ctrl   = req1_ready ? req1_control : req0_control;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    tag_d        = tag_q;
    port_d       = port_q;
    ovf_d        = ovf_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          a_d          = req1_ready ? req1_a   : req0_a;
          b_d          = req1_ready ? req1_b   : req0_b;
          tag_d        = req1_ready ? req1_tag : req0_tag;
          ctrl_d       = sel_ctrl;
          port_d       = req1_ready;
          last_grant_d = req1_ready;
          cnt_d        = exec_cycles(sel_ctrl[22:19]);
          ovf_d        = 1'b0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        // The flag is combinational off the held operands, so it is captured on the last EXEC edge.
        if (cnt_q == 4'd1) begin
          ovf_d   = ibox_flag;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      a_q          <= 64'd0;
      b_q          <= 64'd0;
      ctrl_q       <= 31'd0;
      tag_q        <= '0;
      port_q       <= 1'b0;
      ovf_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      tag_q        <= tag_d;
      port_q       <= port_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Every output is forced low while rst is high, even before the reset edge lands.
  assign ibox_a       = rst ? 64'd0 : a_q;
  assign ibox_b       = rst ? 64'd0 : b_q;
  assign ibox_control = (rst || state_q == IDLE) ? 31'd0 : ctrl_q;

  assign busy        = ~rst & (state_q != IDLE);
  assign resp_valid  = ~rst & (state_q == RESP);
  assign resp_port   = resp_valid & port_q;
  assign resp_tag    = resp_valid ? tag_q : '0;
  assign resp_result = resp_valid ? ibox_result : 64'd0;
  assign resp_ovf    = resp_valid & ovf_q;

  a_one_grant: assert property (@(posedge clk) !(req0_ready && req1_ready));
  a_no_grant_busy: assert property (@(posedge clk) busy |-> !(req0_ready || req1_ready));
  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_tag) && $stable(resp_port)
                                     && $stable(resp_result) && $stable(resp_ovf)));
  a_ibox_hold: assert property (@(posedge clk) disable iff (rst)
    (busy && state_q != RESP) |=> ($stable(ibox_a) && $stable(ibox_b) && $stable(ibox_control)));

endmodule

// File: tb/tb_ibox_sched.sv
// Directed bench for ibox_sched with a small behavioural Ibox (add, multiply, xor).
module tb_ibox_sched;
  localparam int TAG_W = 4;
  localparam logic [30:0] C_ADD  = 31'h0008_0000;
  localparam logic [30:0] C_ADDV = 31'h0008_0001;
  localparam logic [30:0] C_MUL  = 31'h0038_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0]      req0_a, req0_b, req1_a, req1_b;
  logic [30:0]      req0_control, req1_control;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [63:0]      ibox_a, ibox_b, ibox_result, sum;
  logic [30:0]      ibox_control;
  logic             ibox_flag;
  logic             resp_valid, resp_ready, resp_port, resp_ovf, busy;
  logic [TAG_W-1:0] resp_tag;
  logic [63:0]      resp_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ibox_sched #(.MUL_LATENCY(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_control(req0_control), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_control(req1_control), .req1_tag(req1_tag),
    .ibox_a(ibox_a), .ibox_b(ibox_b), .ibox_control(ibox_control),
    .ibox_result(ibox_result), .ibox_flag(ibox_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port),
    .resp_tag(resp_tag), .resp_result(resp_result), .resp_ovf(resp_ovf), .busy(busy)
  );

  // Ibox stand-in: registered result, combinational signed-add overflow flag gated by control[0].
  assign sum       = ibox_a + ibox_b;
  assign ibox_flag = ibox_control[0] && (ibox_control[22:19] == 4'd1) &&
                     (ibox_a[63] == ibox_b[63]) && (sum[63] != ibox_a[63]);
  always @(posedge clk) begin
    case (ibox_control[22:19])
      4'd1:    ibox_result <= sum;
      4'd7:    ibox_result <= ibox_a * ibox_b;
      default: ibox_result <= ibox_a ^ ibox_b;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [30:0] ctl,
                       input logic [TAG_W-1:0] tg);
    req0_a = a; req0_b = b; req0_control = ctl; req0_tag = tg;
    req1_a = a; req1_b = b; req1_control = ctl; req1_tag = tg;
  endtask

  task automatic chk_resp(input int p, input logic [TAG_W-1:0] tg, input logic [63:0] er, input logic eo);
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("resp_port",  64'(resp_port), 64'(p));
    chk("resp_tag",   64'(resp_tag), 64'(tg));
    chk("resp_result", resp_result, er);
    chk("resp_ovf",   64'(resp_ovf), 64'(eo));
  endtask

  // Issues one op on port p from IDLE, checks exec length, held Ibox inputs and response.
  task automatic run_op(input int p, input logic [63:0] a, input logic [63:0] b, input logic [30:0] ctl,
                        input logic [TAG_W-1:0] tg, input logic [63:0] er, input logic eo,
                        input int ecyc, input int hold);
    int n;
    drive(a, b, ctl, tg);
    req0_valid = (p == 0);
    req1_valid = (p == 1);
    #1;
    chk("grant_p0", 64'(req0_ready), 64'(p == 0));
    chk("grant_p1", 64'(req1_ready), 64'(p == 1));
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin
      #1;
      chk("exec_busy", 64'(busy), 64'd1);
      chk("exec_no_grant", 64'({req0_ready, req1_ready}), 64'd0);
      chk("exec_ibox_a", ibox_a, a);
      chk("exec_ibox_b", ibox_b, b);
      chk("exec_ibox_ctl", 64'(ibox_control), 64'(ctl));
      n++;
      step();
    end
    chk("exec_cycles", 64'(n), 64'(ecyc));
    for (int h = 0; h < hold; h++) begin
      chk_resp(p, tg, er, eo);
      chk("hold_no_grant", 64'({req0_ready, req1_ready}), 64'd0);
      chk("hold_ibox_a", ibox_a, a);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk_resp(p, tg, er, eo);
    chk("resp_busy", 64'(busy), 64'd1);
    step();
    resp_ready = 1'b0;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_resp_valid", 64'(resp_valid), 64'd0);
    chk("idle_ibox_ctl", 64'(ibox_control), 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    resp_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    drive(64'd1, 64'd2, C_ADD, 4'd1);
    step();
    step();
    chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_ibox_ctl", 64'(ibox_control), 64'd0);
    chk("rst_ibox_a", ibox_a, 64'd0);

    // Single add straight out of reset: ready in the first cycle, response 2 cycles after transfer.
    rst = 1'b0;
    run_op(0, 64'd5, 64'd3, C_ADD, 4'd2, 64'd8, 1'b0, 1, 0);

    // Multiply: 4 EXEC cycles, response on the 5th cycle after transfer.
    run_op(1, 64'd6, 64'd7, C_MUL, 4'd9, 64'd42, 1'b0, 4, 0);

    // ALU op 12 is single-cycle.
    run_op(0, 64'hF0, 64'h0F, 31'h0060_0000, 4'd3, 64'hFF, 1'b0, 1, 0);

    // Signed overflow with and without trap enable.
    run_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, C_ADDV, 4'd4, 64'h8000_0000_0000_0000, 1'b1, 1, 0);
    run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, C_ADD, 4'd5, 64'h8000_0000_0000_0000, 1'b0, 1, 0);

    // Consumer back-pressure for 5 cycles.
    run_op(1, 64'd100, 64'd23, C_ADD, 4'd6, 64'd123, 1'b0, 1, 5);

    // Round-robin after reset with both ports continuously valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_a = 64'd10;  req0_b = 64'd20; req0_control = C_ADD; req0_tag = 4'hA;
    req1_a = 64'd100; req1_b = 64'd1;  req1_control = C_ADD; req1_tag = 4'h5;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", 64'(req0_ready), 64'(k % 2 == 0));
      chk("rr_ready1", 64'(req1_ready), 64'(k % 2 == 1));
      step();
      n = 0;
      while (!resp_valid && n < 20) begin
        step();
        n++;
      end
      if (k % 2 == 0) chk_resp(0, 4'hA, 64'd30, 1'b0);
      else            chk_resp(1, 4'h5, 64'd101, 1'b0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    step();

    // Reset during multiply EXEC after a port-0 grant: aborted, and the next tie still goes to port 0.
    drive(64'd3, 64'd3, C_MUL, 4'd7);
    req0_valid = 1'b1;
    step();
    step();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk("abort_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_ibox_a", ibox_a, 64'd0);
    chk("abort_ibox_ctl", 64'(ibox_control), 64'd0);
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      seen += int'(resp_valid) + int'(busy);
      step();
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_rst_tie0", 64'(req0_ready), 64'd1);
    chk("post_rst_tie1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    chk_resp(0, 4'd7, 64'd9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
